mix_column_engine: RTL and testbench

Parametrised, handshaked AES MixColumns/InvMixColumns engine operating on a 128-bit state. It processes COLS_PER_CYCLE columns per clock, so one GF(2^8) column datapath can be shared across the four columns to save area. It sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round datapath. A per-transaction bypass serves the final round, which has no MixColumns.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/mix_column_col.sv | 50 +++++
 rtl/mix_column_engine.sv | 133 +++++++++++++
 tb/tb_mix_column_engine.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, field constant and GF(2^8) multiply helpers.
// The helpers are built from xtime chains, so there are no lookup tables.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [7:0]   byte_t;

  // Low byte of the field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t gf_mul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

  function automatic byte_t gf_mul9(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic byte_t gf_mulB(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic byte_t gf_mulD(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic byte_t gf_mulE(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_column_col.sv
// Combinational single-column MixColumns / InvMixColumns transform.
// Byte 0 of the column sits in the MSBs. When INV_EN is 0 the inverse
// datapath is not generated and mode_i has no effect.
module mix_column_col
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [31:0] col_i,
  input  logic        mode_i,
  output logic [31:0] col_o
);

  byte_t a0, a1, a2, a3;
  col_t  fwd;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Forward transform: rows of the circulant matrix {02,03,01,01}.
  always_comb begin
    fwd = '0;
    fwd[31:24] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
    fwd[23:16] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
    fwd[15:8]  = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
    fwd[7:0]   = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
  end

  if (INV_EN) begin : g_inv
    col_t inv;

    // Inverse transform: rows of the circulant matrix {0E,0B,0D,09}.
    always_comb begin
      inv = '0;
      inv[31:24] = gf_mulE(a0) ^ gf_mulB(a1) ^ gf_mulD(a2) ^ gf_mul9(a3);
      inv[23:16] = gf_mul9(a0) ^ gf_mulE(a1) ^ gf_mulB(a2) ^ gf_mulD(a3);
      inv[15:8]  = gf_mulD(a0) ^ gf_mul9(a1) ^ gf_mulE(a2) ^ gf_mulB(a3);
      inv[7:0]   = gf_mulB(a0) ^ gf_mulD(a1) ^ gf_mul9(a2) ^ gf_mulE(a3);
    end

    assign col_o = mode_i ? inv : fwd;
  end else begin : g_fwd_only
    logic unused_mode;
    assign unused_mode = mode_i;
    assign col_o = fwd;
  end

endmodule

// File: rtl/mix_column_engine.sv
// Handshaked MixColumns/InvMixColumns engine for a 128-bit AES state.
// COLS_PER_CYCLE column datapaths are time-shared across the four columns,
// so a result takes 4/COLS_PER_CYCLE busy cycles. Bypass skips the
// transform for the final round. A result waiting in DONE can be
// accepted in the same cycle as the next input, so there is no bubble.
module mix_column_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_mode,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  state_t     data_q, data_d;
  logic       mode_q, mode_d;
  logic       out_valid_q, out_valid_d;

  col_t       cols [4];
  col_t       col_in  [COLS_PER_CYCLE];
  col_t       col_out [COLS_PER_CYCLE];
  logic [1:0] col_idx [COLS_PER_CYCLE];
  state_t     data_mixed;
  logic       accept;

  assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

  // Pick the columns handled this cycle, column 0 (MSBs) first.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols[c] = data_q[127 - 32*c -: 32];
    end
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      col_idx[i] = 2'(int'(cnt_q) * COLS_PER_CYCLE + i);
      col_in[i]  = cols[col_idx[i]];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    mix_column_col #(
      .INV_EN (INV_EN)
    ) u_col (
      .col_i  (col_in[g]),
      .mode_i (mode_q),
      .col_o  (col_out[g])
    );
  end

  // Write the transformed columns back into their slots of the state.
  always_comb begin
    data_mixed = data_q;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      data_mixed[127 - 32*int'(col_idx[i]) -: 32] = col_out[i];
    end
  end

  // Next-state logic: load on handshake, step the column counter while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = in_data;
          mode_d  = INV_EN ? in_mode : 1'b0;
          cnt_d   = 2'd0;
          state_d = in_bypass ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        data_d = data_mixed;
        if (cnt_q == 2'(NCYC - 1)) begin
          cnt_d   = 2'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (accept) begin
          data_d  = in_data;
          mode_d  = INV_EN ? in_mode : 1'b0;
          cnt_d   = 2'd0;
          state_d = in_bypass ? ST_DONE : ST_BUSY;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
  end

  // State, counter, data and valid registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      data_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mix_column_engine.sv
// Directed bench for mix_column_engine: reset values, forward/inverse
// vectors at every column width, bypass, stall/back-to-back, reset in
// the middle of a transform, and a random forward->inverse round trip.
module tb_mix_column_engine;

  localparam logic [127:0] FWD_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] BYP_IN  = 128'hd4d4d4d52d26314c0123456789abcdef;
  localparam logic [63:0]  BYP_MIX = 64'hd5d5d7d64d7ebdf8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic         in_mode, in_bypass, out_ready;
  logic         in_valid1, in_valid2, in_valid4;
  logic         in_ready1, in_ready2, in_ready4;
  logic         out_valid1, out_valid2, out_valid4;
  logic [127:0] out_data1, out_data2, out_data4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mix_column_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_mode(in_mode), .in_bypass(in_bypass),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1));

  mix_column_engine #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .in_bypass(in_bypass),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2));

  mix_column_engine #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .in_bypass(in_bypass),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4));

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count edges, including the accept edge, until out_valid of the width-1 engine rises.
  task automatic waitOutput(output int lat);
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [127:0] data, input logic mode, input logic byp,
                               output int lat, output logic [127:0] res);
    int guard;
    in_data   = data;
    in_mode   = mode;
    in_bypass = byp;
    in_valid1 = 1'b1;
    #1;
    guard = 0;
    while (!in_ready1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) checkOutput("accept_timeout", 128'(guard), 128'd0);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    waitOutput(lat);
    res = out_data1;
  endtask

  initial begin
    int lat, l1, l2, l4;
    logic [127:0] res, held, d1, d2, d4, orig, mid;

    rst_n = 1'b0;
    in_data = '0; in_mode = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;

    // Reset values.
    #2;
    checkOutput("reset_out_valid", 128'(out_valid1), 128'd0);
    checkOutput("reset_out_data", out_data1, 128'd0);
    checkOutput("reset_in_ready", 128'(in_ready1), 128'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_in_ready", 128'({in_ready1, in_ready2, in_ready4}), 128'h7);

    // Forward vector, one column per cycle.
    applyStimulus(FWD_IN, 1'b0, 1'b0, lat, res);
    checkOutput("fwd_data", res, FWD_OUT);
    checkOutput("fwd_latency", 128'(lat), 128'd5);

    // Inverse vector on all three column widths accepted on the same edge.
    repeat (2) @(posedge clk);
    #1;
    in_data = FWD_OUT; in_mode = 1'b1; in_bypass = 1'b0;
    in_valid1 = 1'b1; in_valid2 = 1'b1; in_valid4 = 1'b1;
    #1;
    checkOutput("inv_in_ready", 128'({in_ready1, in_ready2, in_ready4}), 128'h7);
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;
    l1 = 0; l2 = 0; l4 = 0; d1 = '0; d2 = '0; d4 = '0;
    for (int e = 1; e <= 10; e++) begin
      if (out_valid1 && l1 == 0) begin l1 = e; d1 = out_data1; end
      if (out_valid2 && l2 == 0) begin l2 = e; d2 = out_data2; end
      if (out_valid4 && l4 == 0) begin l4 = e; d4 = out_data4; end
      @(posedge clk); #1;
    end
    checkOutput("inv1_data", d1, FWD_IN);
    checkOutput("inv2_data", d2, FWD_IN);
    checkOutput("inv4_data", d4, FWD_IN);
    checkOutput("inv1_latency", 128'(l1), 128'd5);
    checkOutput("inv2_latency", 128'(l2), 128'd3);
    checkOutput("inv4_latency", 128'(l4), 128'd2);

    // Bypass passes the state unchanged; the same state mixed differs.
    applyStimulus(BYP_IN, 1'b0, 1'b1, lat, res);
    checkOutput("bypass_data", res, BYP_IN);
    checkOutput("bypass_latency", 128'(lat), 128'd1);
    applyStimulus(BYP_IN, 1'b0, 1'b0, lat, res);
    checkOutput("nobypass_cols01", 128'(res[127:64]), 128'(BYP_MIX));

    // Stall for ten cycles with a competing input, then release back-to-back.
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(BYP_IN, 1'b0, 1'b1, lat, res);
    held = out_data1;
    in_data = FWD_IN; in_mode = 1'b0; in_bypass = 1'b0; in_valid1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checkOutput("stall_data", out_data1, BYP_IN);
      checkOutput("stall_valid_ready", 128'({out_valid1, in_ready1}), 128'h2);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 128'(in_ready1), 128'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    checkOutput("b2b_busy", 128'({out_valid1, in_ready1}), 128'h0);
    waitOutput(lat);
    checkOutput("b2b_data", out_data1, FWD_OUT);
    checkOutput("b2b_latency", 128'(lat), 128'd5);

    // Reset while the counter is at 2, then a clean transfer.
    repeat (2) @(posedge clk);
    #1;
    in_data = FWD_IN; in_mode = 1'b0; in_bypass = 1'b0; in_valid1 = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 128'(out_valid1), 128'd0);
    checkOutput("midreset_out_data", out_data1, 128'd0);
    checkOutput("midreset_in_ready", 128'(in_ready1), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(FWD_OUT, 1'b1, 1'b0, lat, res);
    checkOutput("after_reset_data", res, FWD_IN);
    checkOutput("after_reset_latency", 128'(lat), 128'd5);

    // Random round trip: inverse(forward(x)) must return x.
    for (int n = 0; n < 1000; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(orig, 1'b0, 1'b0, lat, mid);
      applyStimulus(mid, 1'b1, 1'b0, lat, res);
      checkOutput("round_trip", res, orig);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
